// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: bus widths, register map,
// FSM encodings and the status-word packing helper.
package intc_pkg;

    localparam int mem_addr_w = 32;
    localparam int data_w     = 32;
    localparam int intc_id_w  = 5;

    typedef logic [mem_addr_w-1:0] mem_addr_bus_t;
    typedef logic [data_w-1:0]     data_bus_t;

    localparam logic      rst_enable = 1'b1;
    localparam data_bus_t data_zero  = '0;

    localparam mem_addr_bus_t intc_enable_addr  = 32'h0000_4000;
    localparam mem_addr_bus_t intc_pending_addr = 32'h0000_4004;
    localparam mem_addr_bus_t intc_status_addr  = 32'h0000_4008;

    localparam logic [1:0] intc_idle   = 2'd0;
    localparam logic [1:0] intc_req    = 2'd1;
    localparam logic [1:0] intc_active = 2'd2;

    // Status word: bit 0 REQ, bit 1 ACTIVE, bits 12:8 current id.
    function automatic data_bus_t intc_status_word(input logic req,
                                                   input logic active,
                                                   input logic [intc_id_w-1:0] id);
        data_bus_t w;
        w       = data_zero;
        w[0]    = req;
        w[1]    = active;
        w[12:8] = id;
        return w;
    endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational lowest-index priority encoder; index 0 wins.
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int IRQ_NUM = 8
) (
    input  logic [IRQ_NUM-1:0]   req_vec,
    output logic [intc_id_w-1:0] id,
    output logic                 valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        id    = '0;
        valid = 1'b0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                id    = intc_id_w'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc.sv
// Fixed-priority interrupt controller: edge-latched pending bits gated by an
// enable mask, single request to the core with ack/done handshake.
module intc
    import intc_pkg::*;
#(
    parameter int IRQ_NUM = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IRQ_NUM-1:0]    irq_src_i,
    input  logic [mem_addr_w-1:0] intc_r_addr_i,
    input  logic [mem_addr_w-1:0] intc_w_addr_i,
    input  logic [data_w-1:0]     intc_data_i,
    input  logic                  intc_r_enable_i,
    input  logic                  intc_w_enable_i,
    output logic [data_w-1:0]     intc_data_o,
    input  logic                  irq_ack_i,
    input  logic                  irq_done_i,
    output logic                  irq_req_o,
    output logic [intc_id_w-1:0]  irq_id_o
);

    logic [IRQ_NUM-1:0]   src_prev;
    logic [IRQ_NUM-1:0]   rise;
    logic [IRQ_NUM-1:0]   enable;
    logic [IRQ_NUM-1:0]   pending;
    logic [IRQ_NUM-1:0]   w1c_mask;
    logic [IRQ_NUM-1:0]   ack_mask;
    logic [IRQ_NUM-1:0]   cand_vec;
    logic [intc_id_w-1:0] cand_id;
    logic                 cand_vld;
    logic [1:0]           state;
    logic                 en_wr;
    logic                 pend_wr;
    logic                 ack_take;
    logic                 done_take;
    data_bus_t            rd_data;
    logic                 unused_wdata;

    // Only the low IRQ_NUM bits of the write bus carry meaning.
    assign unused_wdata = ^intc_data_i;

    always_comb begin
        rise      = irq_src_i & ~src_prev;
        en_wr     = intc_w_enable_i && (intc_w_addr_i == intc_enable_addr);
        pend_wr   = intc_w_enable_i && (intc_w_addr_i == intc_pending_addr);
        w1c_mask  = pend_wr ? intc_data_i[IRQ_NUM-1:0] : '0;
        ack_take  = (state == intc_req) && irq_ack_i;
        done_take = (state == intc_active) && irq_done_i;
        cand_vec  = pending & enable;
    end

    // The acked id's bit is cleared; comparing per bit avoids an oversized index.
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            ack_mask[i] = ack_take && (irq_id_o == intc_id_w'(i));
        end
    end

    intc_prio_enc #(
        .IRQ_NUM (IRQ_NUM)
    ) u_prio_enc (
        .req_vec (cand_vec),
        .id      (cand_id),
        .valid   (cand_vld)
    );

    // A rising edge in the same cycle as a clear keeps the bit set.
    always_ff @(posedge clk) begin
        if (rst_n == rst_enable) begin
            src_prev <= '0;
            enable   <= '0;
            pending  <= '0;
        end else begin
            src_prev <= irq_src_i;
            pending  <= (pending & ~(w1c_mask | ack_mask)) | rise;
            if (en_wr) begin
                enable <= intc_data_i[IRQ_NUM-1:0];
            end
        end
    end

    // Id is latched on entry to REQ and held through ACTIVE.
    always_ff @(posedge clk) begin
        if (rst_n == rst_enable) begin
            state     <= intc_idle;
            irq_req_o <= 1'b0;
            irq_id_o  <= '0;
        end else begin
            case (state)
                intc_idle: begin
                    if (cand_vld) begin
                        irq_id_o  <= cand_id;
                        irq_req_o <= 1'b1;
                        state     <= intc_req;
                    end
                end
                intc_req: begin
                    if (ack_take) begin
                        irq_req_o <= 1'b0;
                        state     <= intc_active;
                    end
                end
                intc_active: begin
                    if (done_take) begin
                        state <= intc_idle;
                    end
                end
                default: begin
                    irq_req_o <= 1'b0;
                    state     <= intc_idle;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = data_zero;
        case (intc_r_addr_i)
            intc_enable_addr:  rd_data[IRQ_NUM-1:0] = enable;
            intc_pending_addr: rd_data[IRQ_NUM-1:0] = pending;
            intc_status_addr:  rd_data = intc_status_word(state == intc_req,
                                                          state == intc_active,
                                                          irq_id_o);
            default:           rd_data = data_zero;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n == rst_enable) begin
            intc_data_o <= data_zero;
        end else if (intc_r_enable_i) begin
            intc_data_o <= rd_data;
        end
    end

endmodule

// File: tb/tb_intc.sv
// Directed bench for intc: a vector table for the basic handshake plus
// hand-written sequences for priority, enable/W1C, re-trigger and reset cases.
module tb_intc;
    import intc_pkg::*;

    localparam int IRQ_NUM = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = rst_enable;
    logic [IRQ_NUM-1:0]    irq_src_i = '0;
    logic [mem_addr_w-1:0] intc_r_addr_i = '0;
    logic [mem_addr_w-1:0] intc_w_addr_i = '0;
    logic [data_w-1:0]     intc_data_i = '0;
    logic                  intc_r_enable_i = 1'b0;
    logic                  intc_w_enable_i = 1'b0;
    logic [data_w-1:0]     intc_data_o;
    logic                  irq_ack_i = 1'b0;
    logic                  irq_done_i = 1'b0;
    logic                  irq_req_o;
    logic [intc_id_w-1:0]  irq_id_o;

    int n_assert = 0;
    int n_fail   = 0;

    intc #(.IRQ_NUM(IRQ_NUM)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_src_i       (irq_src_i),
        .intc_r_addr_i   (intc_r_addr_i),
        .intc_w_addr_i   (intc_w_addr_i),
        .intc_data_i     (intc_data_i),
        .intc_r_enable_i (intc_r_enable_i),
        .intc_w_enable_i (intc_w_enable_i),
        .intc_data_o     (intc_data_o),
        .irq_ack_i       (irq_ack_i),
        .irq_done_i      (irq_done_i),
        .irq_req_o       (irq_req_o),
        .irq_id_o        (irq_id_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    typedef struct {
        logic [IRQ_NUM-1:0] src;
        logic               ack;
        logic               done;
        logic               rd;
        logic [31:0]        raddr;
        logic               exp_req;
        logic [4:0]         exp_id;
        logic               chk_data;
        logic [31:0]        exp_data;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        intc_w_addr_i   = a;
        intc_data_i     = d;
        intc_w_enable_i = 1'b1;
        tick();
        intc_w_enable_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        intc_r_addr_i   = a;
        intc_r_enable_i = 1'b1;
        tick();
        intc_r_enable_i = 1'b0;
        v = intc_data_o;
    endtask

    task automatic pulse(input logic [IRQ_NUM-1:0] s);
        irq_src_i = s;
        tick();
        irq_src_i = '0;
    endtask

    task automatic ack_cycle();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    task automatic done_cycle();
        irq_done_i = 1'b1;
        tick();
        irq_done_i = 1'b0;
    endtask

    initial begin
        logic [31:0] v;

        // src, ack, done, rd, raddr, exp_req, exp_id, chk_data, exp_data
        vecs[0] = '{8'h01, 1'b0, 1'b0, 1'b0, 32'h0,             1'b0, 5'd0, 1'b0, 32'h0};
        vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0,             1'b1, 5'd0, 1'b0, 32'h0};
        vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0,             1'b1, 5'd0, 1'b0, 32'h0};
        vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, intc_pending_addr, 1'b1, 5'd0, 1'b1, 32'h01};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1'b0, 32'h0,             1'b0, 5'd0, 1'b0, 32'h0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, intc_pending_addr, 1'b0, 5'd0, 1'b1, 32'h00};
        vecs[6] = '{8'h00, 1'b0, 1'b0, 1'b1, intc_status_addr,  1'b0, 5'd0, 1'b1, 32'h002};
        vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 32'h0,             1'b0, 5'd0, 1'b0, 32'h0};
        vecs[8] = '{8'h00, 1'b0, 1'b0, 1'b1, intc_status_addr,  1'b0, 5'd0, 1'b1, 32'h000};
        vecs[9] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'h0,             1'b0, 5'd0, 1'b0, 32'h0};

        // Reset state
        tick();
        tick();
        rst_n = ~rst_enable;
        chk("reset_req", 32'(irq_req_o), 32'h0);
        chk("reset_id", 32'(irq_id_o), 32'h0);
        chk("reset_data", intc_data_o, 32'h0);
        rd(intc_enable_addr, v);  chk("reset_enable", v, 32'h0);
        rd(intc_pending_addr, v); chk("reset_pending", v, 32'h0);
        rd(intc_status_addr, v);  chk("reset_status", v, 32'h0);
        chk("reset_req_after_reads", 32'(irq_req_o), 32'h0);

        // Basic handshake from the vector table
        wr(intc_enable_addr, 32'h01);
        rd(intc_enable_addr, v); chk("enable_readback", v, 32'h01);
        for (int i = 0; i < 10; i++) begin
            irq_src_i       = vecs[i].src;
            irq_ack_i       = vecs[i].ack;
            irq_done_i      = vecs[i].done;
            intc_r_enable_i = vecs[i].rd;
            intc_r_addr_i   = vecs[i].raddr;
            tick();
            irq_src_i       = '0;
            irq_ack_i       = 1'b0;
            irq_done_i      = 1'b0;
            intc_r_enable_i = 1'b0;
            chk($sformatf("vec%0d_req", i), 32'(irq_req_o), 32'(vecs[i].exp_req));
            chk($sformatf("vec%0d_id", i), 32'(irq_id_o), 32'(vecs[i].exp_id));
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), intc_data_o, vecs[i].exp_data);
        end

        // Read data holds while the strobe is low; unmapped address reads zero
        rd(intc_enable_addr, v);
        tick();
        chk("data_hold", intc_data_o, 32'h01);
        rd(32'h0000_400C, v); chk("unmapped_read", v, 32'h0);

        // Priority: sources 5 and 2 together, 2 first, 5 two cycles after done
        wr(intc_enable_addr, 32'hFF);
        pulse(8'h24);
        tick();
        chk("prio_req_first", 32'(irq_req_o), 32'h1);
        chk("prio_id_first", 32'(irq_id_o), 32'd2);
        ack_cycle();
        chk("prio_req_after_ack", 32'(irq_req_o), 32'h0);
        rd(intc_pending_addr, v); chk("prio_pending_after_ack", v, 32'h20);
        rd(intc_status_addr, v);  chk("prio_status_active", v, 32'h202);
        done_cycle();
        chk("prio_req_done_plus1", 32'(irq_req_o), 32'h0);
        tick();
        chk("prio_req_done_plus2", 32'(irq_req_o), 32'h1);
        chk("prio_id_second", 32'(irq_id_o), 32'd5);
        ack_cycle();
        done_cycle();

        // Pending while disabled, then enable raises the request two cycles later
        wr(intc_enable_addr, 32'h00);
        pulse(8'h08);
        tick();
        tick();
        chk("dis_no_req", 32'(irq_req_o), 32'h0);
        rd(intc_pending_addr, v); chk("dis_pending", v, 32'h08);
        wr(intc_enable_addr, 32'h08);
        chk("en_req_plus1", 32'(irq_req_o), 32'h0);
        tick();
        chk("en_req_plus2", 32'(irq_req_o), 32'h1);
        chk("en_id", 32'(irq_id_o), 32'd3);
        ack_cycle();
        done_cycle();

        // W1C before enabling: nothing to serve
        wr(intc_enable_addr, 32'h00);
        pulse(8'h08);
        tick();
        rd(intc_pending_addr, v); chk("w1c_pending_before", v, 32'h08);
        wr(intc_pending_addr, 32'h08);
        rd(intc_pending_addr, v); chk("w1c_pending_after", v, 32'h00);
        wr(intc_enable_addr, 32'h08);
        tick();
        tick();
        chk("w1c_no_req", 32'(irq_req_o), 32'h0);

        // Re-trigger in the ack cycle: set beats clear, id 1 served again
        wr(intc_enable_addr, 32'hFF);
        pulse(8'h02);
        tick();
        chk("retrig_req", 32'(irq_req_o), 32'h1);
        chk("retrig_id", 32'(irq_id_o), 32'd1);
        irq_src_i = 8'h02;
        ack_cycle();
        irq_src_i = '0;
        chk("retrig_req_active", 32'(irq_req_o), 32'h0);
        rd(intc_pending_addr, v); chk("retrig_pending_kept", v, 32'h02);
        done_cycle();
        tick();
        chk("retrig_req_again", 32'(irq_req_o), 32'h1);
        chk("retrig_id_again", 32'(irq_id_o), 32'd1);

        // Withdrawing enable or W1C of pending[id] in REQ keeps the request
        wr(intc_enable_addr, 32'h00);
        chk("req_kept_after_disable", 32'(irq_req_o), 32'h1);
        wr(intc_pending_addr, 32'h02);
        chk("req_kept_after_w1c", 32'(irq_req_o), 32'h1);
        chk("req_kept_id", 32'(irq_id_o), 32'd1);
        ack_cycle();
        chk("req_kept_ack", 32'(irq_req_o), 32'h0);
        done_cycle();

        // Reset during REQ aborts immediately
        wr(intc_enable_addr, 32'hFF);
        pulse(8'h10);
        tick();
        chk("rst_pre_req", 32'(irq_req_o), 32'h1);
        chk("rst_pre_id", 32'(irq_id_o), 32'd4);
        rd(intc_enable_addr, v);
        rst_n = rst_enable;
        tick();
        rst_n = ~rst_enable;
        chk("rst_req", 32'(irq_req_o), 32'h0);
        chk("rst_id", 32'(irq_id_o), 32'h0);
        chk("rst_data", intc_data_o, 32'h0);
        rd(intc_enable_addr, v);  chk("rst_enable", v, 32'h0);
        rd(intc_pending_addr, v); chk("rst_pending", v, 32'h0);
        rd(intc_status_addr, v);  chk("rst_status", v, 32'h0);

        // Spurious done in IDLE, spurious ack in ACTIVE
        done_cycle();
        rd(intc_status_addr, v); chk("spur_done_status", v, 32'h0);
        chk("spur_done_req", 32'(irq_req_o), 32'h0);
        wr(intc_enable_addr, 32'h01);
        pulse(8'h01);
        tick();
        chk("spur_setup_req", 32'(irq_req_o), 32'h1);
        ack_cycle();
        ack_cycle();
        chk("spur_ack_req", 32'(irq_req_o), 32'h0);
        rd(intc_status_addr, v); chk("spur_ack_status", v, 32'h002);
        done_cycle();
        rd(intc_status_addr, v); chk("final_status", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/intc.md
# intc

Fixed-priority interrupt controller that collects the `irq_o` lines of the peripherals (timer, and later UART/GPIO) and presents a single request to the core. It latches rising edges into a pending register, gates them with a software-written enable register, and runs a request/acknowledge/complete handshake with the core's trap logic. It is a memory-mapped slave on the same peripheral read/write port as the other peripherals.

## Interface
- `IRQ_NUM`, 8: number of interrupt sources, legal range 1..32; source 0 has the highest priority.
- `clk` input 1: single system clock, all logic on posedge.
- `rst_n` input 1: synchronous, active-high reset, asserted when `rst_n == `rst_enable` (`rst_enable` = 1'b1).
- `irq_src_i` input IRQ_NUM: peripheral interrupt lines, synchronous to `clk`.
- `intc_r_addr_i` input `mem_addr_bus`: read address.
- `intc_w_addr_i` input `mem_addr_bus`: write address.
- `intc_data_i` input `data_bus`: write data.
- `intc_r_enable_i` input 1: read strobe.
- `intc_w_enable_i` input 1: write strobe.
- `intc_data_o` output `data_bus`: registered read data.
- `irq_ack_i` input 1: core accepted the request (trap entry).
- `irq_done_i` input 1: core finished the handler (return from trap).
- `irq_req_o` output 1: interrupt request to core.
- `irq_id_o` output 5: index of the requested/active source.

## Operation
- Registers: `enable` (RW, IRQ_NUM bits, upper bits read 0); `pending` (read; write-1-to-clear); `status` (read-only: bit 0 = REQ, bit 1 = ACTIVE, bits 12:8 = current id; writes ignored).
- Edge detect: `src_prev <= irq_src_i`; edge = `irq_src_i & ~src_prev`; each edge bit sets its `pending` bit. Level-high sources do not re-trigger.
- Candidate = lowest index i with `pending[i] & enable[i]`.
- FSM states:
  - IDLE: if any candidate exists, latch its id into `irq_id_o`, go to REQ.
  - REQ: `irq_req_o` = 1, id frozen. On `irq_ack_i`: clear `pending[id]`, go to ACTIVE.
  - ACTIVE: `irq_req_o` = 0, id held. On `irq_done_i`: go to IDLE.
- `irq_ack_i` outside REQ and `irq_done_i` outside ACTIVE are ignored.
- No nesting: new candidates wait in `pending` until IDLE.
- Same-cycle set (edge) and clear (ack or W1C) of one pending bit: set wins.
- Clearing `enable[id]` or W1C of `pending[id]` while in REQ does not withdraw the request; the request stays until ack.
- Read decode: `enable`, `pending`, `status` at `intc_enable_addr`, `intc_pending_addr`, `intc_status_addr`. An unmapped read address returns `data_zero`. With `intc_r_enable_i` low, `intc_data_o` holds its value.

## Timing
- Reset: `irq_req_o` = 0, `irq_id_o` = 0, `intc_data_o` = 0, `enable` = 0, `pending` = 0, `src_prev` = 0, state IDLE. Reset during REQ or ACTIVE aborts the handshake immediately.
- Source rising at cycle N: `pending` set at edge N+1; if enabled and IDLE, `irq_req_o` high from N+2.
- `irq_ack_i` high in cycle M while in REQ: `irq_req_o` low from M+1; the pending bit is clear from M+1.
- `irq_done_i` in cycle K while in ACTIVE: IDLE at K+1; the next request can assert at K+2.
- Register read: data valid one cycle after the strobe. Register write: takes effect on the next edge. Writing `enable` 1 with the bit already pending raises the request two cycles later.

## Structure
- Add `intc_enable_addr`, `intc_pending_addr`, `intc_status_addr` and state encodings (`intc_idle`, `intc_req`, `intc_active`) to `define.v`.
- One optional sub-module, `intc_prio_enc`: a combinational lowest-index priority encoder (IRQ_NUM bits in, 5-bit id plus a valid bit out).

## Test plan
- Reset, then read all three registers: each returns 0x0; `irq_req_o` = 0.
- `enable` = 0x01, pulse `irq_src_i[0]` at cycle 10: `irq_req_o` = 1 at cycle 12 with `irq_id_o` = 0. Ack at 15: req = 0 at 16, `pending` = 0x0, status = 0x002. Done: status = 0x000.
- `enable` = 0xFF, raise sources 5 and 2 together: id 2 is served first. After done, id 5 is requested two cycles later.
- Source 3 pulsed with `enable` = 0: `pending` = 0x08 and no request. Write `enable` = 0x08: request with id 3 after 2 cycles. Repeat, then W1C `pending` with 0x08 before enabling: no request.
- During ACTIVE on id 1, re-pulse source 1 in the ack cycle: `pending[1]` remains set, and after done id 1 is requested again.
- Assert reset while in REQ: the next cycle has `irq_req_o` = 0 and all registers 0. Spurious `irq_done_i` in IDLE and spurious `irq_ack_i` in ACTIVE cause no state change.
